seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture_pkg.sv | 29 ++
 rtl/seg_capture_fifo.sv | 61 ++++++
 rtl/seg_capture.sv | 106 ++++++++++
 tb/tb_seg_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_capture_pkg.sv
// Shared glyph constants and the seven-segment decoder used by seg_capture.
package seg_capture_pkg;

    localparam logic [6:0] BLANK = 7'h00;

    // Index of each entry is the hex value it displays.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic       hit;
        logic [3:0] value;
    } decode_t;

    function automatic decode_t decode_glyph(input logic [6:0] seg);
        decode_t r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH_TABLE[i]) begin
                r.hit   = 1'b1;
                r.value = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_capture_fifo.sv
// Small digit FIFO; drops (and flags) a push that finds it full with no same-cycle pop.
module seg_capture_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [3:0] data_i,
    input  logic       pop_i,
    output logic [3:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic          do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push    = push_i & (~full_o | do_pop);
    assign data_o     = empty_o ? 4'h0 : mem_q[rd_q];
    assign overflow_o = overflow_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_q | (push_i & full_o & ~do_pop);
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Debounces a seven-segment bus, decodes stable glyphs and queues new digits.
// SEG_CAPTURE_ERRCNT_EN adds the saturating err_count output.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    output logic [3:0] digit,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       overflow,
    output logic       bad_glyph
`ifdef SEG_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

    logic [6:0] sample_q, prev_q;
    logic [6:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       bad_q;
    logic       accept, push, bad_event;
    decode_t    dec;
    logic       fifo_empty, fifo_full;
    logic       unused_full;

    assign unused_full = fifo_full;

    always_comb begin
        cnt_d     = '0;
        accept    = 1'b0;
        push      = 1'b0;
        bad_event = 1'b0;
        last_d    = last_q;
        dec       = decode_glyph(sample_q);
        if (sample_q == prev_q) begin
            cnt_d  = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 4'd1;
            accept = (cnt_q == STABLE_MAX - 4'd1);
        end
        // A blank re-arms capture so the same glyph can be entered twice in a row.
        if (accept) begin
            if (sample_q == BLANK) begin
                last_d = BLANK;
            end else if (sample_q != last_q) begin
                last_d = sample_q;
                if (dec.hit) push = 1'b1;
                else         bad_event = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= BLANK;
            prev_q   <= BLANK;
            cnt_q    <= '0;
            last_q   <= BLANK;
            bad_q    <= 1'b0;
        end else begin
            sample_q <= segments;
            prev_q   <= sample_q;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            bad_q    <= bad_q | bad_event;
        end
    end

    seg_capture_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .data_i     (dec.value),
        .pop_i      (digit_ready),
        .data_o     (digit),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign digit_valid = ~fifo_empty;
    assign bad_glyph   = bad_q;

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (bad_event && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: vector table, directed corner sequences, random run vs. model.
module tb_seg_capture;

    localparam int S = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segments;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       overflow;
    logic       bad_glyph;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    seg_capture #(
        .STABLE_CYCLES (S),
        .DEPTH         (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .segments    (segments),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .overflow    (overflow),
        .bad_glyph   (bad_glyph)
`ifdef SEG_CAPTURE_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: run-length view of the input stream plus a digit queue.
    logic [6:0] glyph [16];
    logic [3:0] mq [$];
    bit         m_ovf, m_bad;
    int         m_err;
    logic [6:0] m_last, prev_in;
    bit         fresh;
    int         run_len;
    int         pops;
    logic [3:0] popped [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [6:0] s, input bit r, input bit rs);
        bit         acc;
        logic [6:0] pat;
        int         idx;
        if (rs) begin
            mq.delete();
            m_ovf = 0; m_bad = 0; m_err = 0;
            m_last = 7'h00; fresh = 1; run_len = 0;
            return;
        end
        // A pattern seen on S+1 consecutive edges is accepted on the following edge.
        acc = !fresh && (run_len == S + 1);
        pat = prev_in;
        if (r && mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
            idx = lookup(pat);
            if (pat == 7'h00) begin
                m_last = 7'h00;
            end else if (pat != m_last) begin
                m_last = pat;
                if (idx >= 0) begin
                    if (mq.size() < D) mq.push_back(4'(idx));
                    else m_ovf = 1;
                end else begin
                    m_bad = 1;
                    if (m_err < 255) m_err++;
                end
            end
        end
        if (fresh || s != prev_in) run_len = 1;
        else if (run_len < 1000) run_len++;
        prev_in = s;
        fresh = 0;
    endtask

    task automatic tick(input logic [6:0] s, input bit r, input bit rs);
        if (r && digit_valid && !rs) begin
            pops++;
            popped.push_back(digit);
        end
        segments    = s;
        digit_ready = r;
        rst         = rs;
        @(posedge clk);
        model_edge(s, r, rs);
        @(negedge clk);
        chk("digit_valid", 32'(digit_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("digit", 32'(digit), 32'(mq[0]));
        else if (rs)       chk("digit_rst", 32'(digit), 32'h0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("bad_glyph", 32'(bad_glyph), 32'(m_bad));
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(m_err));
`endif
    endtask

    task automatic hold(input logic [6:0] s, input int n, input bit r);
        for (int k = 0; k < n; k++) tick(s, r, 1'b0);
    endtask

    typedef struct {
        bit         rs;
        logic [6:0] seg;
        bit         rdy;
        bit         ev;
        logic [3:0] ed;
        bit         eo;
        bit         eb;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [6:0] cur;
        int         sel, len;

        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        segments = 7'h00; digit_ready = 1'b0; rst = 1'b1;
        fresh = 1; run_len = 0; prev_in = 7'h00; m_last = 7'h00;
        pops = 0;

        // Table: reset, then 06 held 10 cycles with ready=1 -> one digit 1 visible at row 6.
        for (int i = 0; i < 12; i++) begin
            tbl[i].rs = 0; tbl[i].seg = 7'h06; tbl[i].rdy = 1;
            tbl[i].ev = 0; tbl[i].ed = 4'h0; tbl[i].eo = 0; tbl[i].eb = 0;
        end
        tbl[0].rs = 1; tbl[0].seg = 7'h00;
        tbl[6].ev = 1; tbl[6].ed = 4'h1;
        tbl[11].seg = 7'h00;
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].seg, tbl[i].rdy, tbl[i].rs);
            chk("tbl_valid", 32'(digit_valid), 32'(tbl[i].ev));
            if (tbl[i].ev || tbl[i].rs) chk("tbl_digit", 32'(digit), 32'(tbl[i].ed));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[i].eo));
            chk("tbl_bad", 32'(bad_glyph), 32'(tbl[i].eb));
            if (i == 0) pops = 0;
        end
        chk("tbl_single_pop", 32'(pops), 32'd1);
        $display("seq table: 06 held 10 cycles, pops=%0d", pops);

        // Short glitch is ignored.
        tick(7'h00, 0, 1);
        hold(7'h5B, 2, 0);
        hold(7'h4F, 8, 0);
        chk("glitch_valid", 32'(digit_valid), 32'd1);
        chk("glitch_digit", 32'(digit), 32'h3);
        tick(7'h00, 1, 0);
        chk("glitch_only_one", 32'(digit_valid), 32'd0);
        $display("seq glitch: 5B x2 then 4F x8");

        // Blank between repeats re-arms capture; a short gap does not.
        tick(7'h00, 1, 1);
        pops = 0;
        hold(7'h3F, 6, 1); hold(7'h00, 6, 1); hold(7'h3F, 6, 1); hold(7'h00, 3, 1);
        chk("repeat_with_blank", 32'(pops), 32'd2);
        hold(7'h00, 6, 1);
        pops = 0;
        hold(7'h3F, 6, 1); hold(7'h00, 1, 1); hold(7'h3F, 6, 1); hold(7'h00, 3, 1);
        chk("repeat_no_blank", 32'(pops), 32'd1);
        $display("seq repeat: blank-separated and unseparated 3F runs");

        // Overflow with ready low, then drain in order.
        tick(7'h00, 0, 1);
        for (int d = 1; d <= 5; d++) hold(glyph[d], 6, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(digit), 32'h1);
        popped.delete();
        hold(7'h00, 6, 1);
        chk("drain_count", 32'(popped.size()), 32'd4);
        for (int d = 0; d < 4 && d < popped.size(); d++) chk("drain_order", 32'(popped[d]), 32'(d + 1));
        chk("ovf_sticky", 32'(overflow), 32'd1);
        $display("seq overflow: pushed 1..5, drained %0d", popped.size());

        // Undecodable pattern.
        tick(7'h00, 1, 1);
        hold(7'h49, 6, 1);
        chk("bad_set", 32'(bad_glyph), 32'd1);
        chk("bad_no_push", 32'(digit_valid), 32'd0);
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("err_one", 32'(err_count), 32'd1);
`endif
        for (int k = 0; k < 299; k++) begin
            hold(7'h00, 6, 1);
            hold(7'h49, 6, 1);
        end
        chk("bad_sticky", 32'(bad_glyph), 32'd1);
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("err_saturate", 32'(err_count), 32'd255);
`endif
        $display("seq bad glyph: 300 events of 49");

        // Reset mid-run discards the partial run.
        tick(7'h00, 0, 1);
        hold(7'h66, 2, 0);
        tick(7'h66, 0, 1);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_bad", 32'(bad_glyph), 32'd0);
        hold(7'h66, 5, 0);
        chk("rst_rerun_early", 32'(digit_valid), 32'd0);
        hold(7'h66, 1, 0);
        chk("rst_rerun_valid", 32'(digit_valid), 32'd1);
        chk("rst_rerun_digit", 32'(digit), 32'h4);
        $display("seq reset: 66 run restarted after reset");

        // Random runs checked against the model each cycle.
        cur = 7'h00;
        tick(7'h00, 0, 1);
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       cur = glyph[$urandom_range(0, 15)];
            else if (sel == 6) cur = 7'h00;
            else if (sel == 7) cur = 7'h49;
            else if (sel == 8) cur = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                tick(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
        end
        $display("seq random: 300 runs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
